// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: handshake/bus bundle between the upstream byte source and
// the UART TX control FSM.
//   P_DATA     : parallel word to transmit
//   DATA_VALID : transmit request (pulse or level)
//   PAR_EN     : 1 = insert a parity bit
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   mux_sel    : 00 stop/idle, 01 start, 10 data, 11 parity
//   ser_data   : current serialized data bit
//   par_bit    : parity of the latched word
//   busy       : high from the START cycle through the STOP cycle
// master = upstream source (test harness), slave = the FSM.
interface uart_tx_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: control/serialization stage feeding the UART TX output mux.
// One frame bit per CLK (CLK is the baud clock): START, DATA (LSB first),
// optional PARITY, STOP. A request seen in IDLE or STOP is accepted; in STOP
// this gives back-to-back frames with no idle gap.
// Ports:
//   CLK : baud-rate clock, rising edge
//   RST : synchronous reset, active high (wins over a same-edge request)
//   bus : uart_tx_fsm_if.slave (P_DATA/DATA_VALID/PAR_EN/PAR_TYP in,
//         mux_sel/ser_data/par_bit/busy out)
// All outputs are registers, updated together with the state.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  uart_tx_fsm_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_ser;
  logic                  r_busy;
  logic [1:0]            r_mux;

  logic w_accept;
  logic w_par;

  assign w_accept = bus.DATA_VALID && ((r_state == S_IDLE) || (r_state == S_STOP));
  // PAR_TYP is folded into the parity bit at acceptance, so only the result
  // needs to be held for the frame in flight.
  assign w_par    = bus.PAR_TYP ? ~(^bus.P_DATA) : (^bus.P_DATA);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_ser     <= 1'b0;
      r_busy    <= 1'b0;
      r_mux     <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_STOP: begin
          if (w_accept) begin
            r_shift   <= bus.P_DATA;
            r_par_en  <= bus.PAR_EN;
            r_par_bit <= w_par;
            r_state   <= S_START;
            r_mux     <= 2'b01;
            r_busy    <= 1'b1;
          end else begin
            r_state   <= S_IDLE;
            r_mux     <= 2'b00;
            r_busy    <= 1'b0;
          end
        end
        S_START: begin
          // ser_data is registered, so the first bit is loaded on the edge
          // that enters DATA; each later DATA edge loads the next bit.
          r_state <= S_DATA;
          r_mux   <= 2'b10;
          r_cnt   <= '0;
          r_ser   <= r_shift[0];
          r_shift <= r_shift >> 1;
        end
        S_DATA: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            if (r_par_en) begin
              r_state <= S_PARITY;
              r_mux   <= 2'b11;
            end else begin
              r_state <= S_STOP;
              r_mux   <= 2'b00;
            end
          end else begin
            r_ser   <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        S_PARITY: begin
          r_state <= S_STOP;
          r_mux   <= 2'b00;
        end
        default: begin
          r_state <= S_IDLE;
          r_mux   <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel  = r_mux;
  assign bus.ser_data = r_ser;
  assign bus.par_bit  = r_par_bit;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: a frame-level model (queue of expected per-cycle
// outputs built whenever a request is accepted) checked every cycle, plus
// hand-computed literal checks on measured frames.
module tb_uart_tx_fsm;
  localparam int DW = 8;

  logic CLK;
  logic RST;
  uart_tx_fsm_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // ---------------- model ----------------
  typedef struct packed {
    logic [1:0] m;
    logic       b;
    logic       s;
    logic       sv;
  } ent_t;

  ent_t       q[$];
  logic [1:0] exp_mux = 2'b00;
  logic       exp_busy = 1'b0;
  logic       exp_ser = 1'b0;
  logic       exp_par = 1'b0;

  function automatic ent_t mk(logic [1:0] m, logic s, logic sv);
    ent_t e;
    e.m = m; e.b = 1'b1; e.s = s; e.sv = sv;
    return e;
  endfunction

  task automatic pop_ent();
    ent_t e;
    e = q.pop_front();
    exp_mux  = e.m;
    exp_busy = e.b;
    if (e.sv) exp_ser = e.s;
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      q.delete();
      exp_mux = 2'b00; exp_busy = 1'b0; exp_ser = 1'b0; exp_par = 1'b0;
    end else if (exp_mux == 2'b00 && bus.DATA_VALID) begin
      // line is at idle/stop level: a request starts a whole new frame
      q.delete();
      q.push_back(mk(2'b01, 1'b0, 1'b0));
      for (int i = 0; i < DW; i++) q.push_back(mk(2'b10, bus.P_DATA[i], 1'b1));
      if (bus.PAR_EN) q.push_back(mk(2'b11, 1'b0, 1'b0));
      q.push_back(mk(2'b00, 1'b0, 1'b0));
      exp_par = bus.PAR_TYP ? ~(^bus.P_DATA) : (^bus.P_DATA);
      pop_ent();
    end else if (q.size() != 0) begin
      pop_ent();
    end else begin
      exp_mux = 2'b00; exp_busy = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      n_cmp++;
      if (bus.mux_sel !== exp_mux) begin
        n_err++; $display("FAIL mux_sel t=%0t got=%b want=%b", $time, bus.mux_sel, exp_mux);
      end
      n_cmp++;
      if (bus.busy !== exp_busy) begin
        n_err++; $display("FAIL busy t=%0t got=%b want=%b", $time, bus.busy, exp_busy);
      end
      n_cmp++;
      if (bus.ser_data !== exp_ser) begin
        n_err++; $display("FAIL ser_data t=%0t got=%b want=%b", $time, bus.ser_data, exp_ser);
      end
      n_cmp++;
      if (bus.par_bit !== exp_par) begin
        n_err++; $display("FAIL par_bit t=%0t got=%b want=%b", $time, bus.par_bit, exp_par);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Called at the negedge showing START; walks the frame until busy drops.
  // inj_at >= 0 injects an ignored request (P_DATA=0, PAR_TYP toggled) for
  // two cycles starting at that frame cycle index.
  task automatic measure(input int inj_at, output int bcyc, output logic [7:0] b,
                         output logic p, output bit saw_p);
    int nb;
    bit done;
    bcyc = 0; b = 8'h00; p = 1'b0; saw_p = 0; nb = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.busy) begin
        bcyc++;
        if (bus.mux_sel == 2'b10 && nb < 8) begin b[nb] = bus.ser_data; nb++; end
        if (bus.mux_sel == 2'b11) begin p = bus.par_bit; saw_p = 1; end
      end else if (bcyc > 0) begin
        done = 1;
      end
      if (!done) begin
        if (k == inj_at) begin
          bus.DATA_VALID = 1'b1; bus.P_DATA = 8'h00; bus.PAR_TYP = ~bus.PAR_TYP;
        end
        if (inj_at >= 0 && k == inj_at + 2) bus.DATA_VALID = 1'b0;
        @(negedge CLK);
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL frame_timeout busy_cycles=%0d want=frame end", bcyc);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic en, input logic typ);
    bus.P_DATA = d; bus.PAR_EN = en; bus.PAR_TYP = typ; bus.DATA_VALID = 1'b1;
    @(negedge CLK);
    bus.DATA_VALID = 1'b0;
  endtask

  int         bc;
  logic [7:0] by;
  logic       pb;
  bit         sp;
  bit         found;

  initial begin
    RST = 1'b1;
    bus.P_DATA = 8'h00; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_en = 1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_mux", int'(bus.mux_sel), 0);
    chk("idle_busy", int'(bus.busy), 0);

    // even parity, 0xA5
    send(8'hA5, 1'b1, 1'b0);
    chk("start_mux", int'(bus.mux_sel), 1);
    measure(-1, bc, by, pb, sp);
    chk("even_busy_cycles", bc, 11);
    chk("even_data", int'(by), 8'hA5);
    chk("even_par", int'(pb), 0);
    chk("even_saw_par", int'(sp), 1);
    repeat (2) @(negedge CLK);

    // odd parity, 0xA5
    send(8'hA5, 1'b1, 1'b1);
    measure(-1, bc, by, pb, sp);
    chk("odd_busy_cycles", bc, 11);
    chk("odd_par", int'(pb), 1);

    // no parity, 0xA5
    send(8'hA5, 1'b0, 1'b0);
    measure(-1, bc, by, pb, sp);
    chk("nopar_busy_cycles", bc, 10);
    chk("nopar_saw_par", int'(sp), 0);
    chk("nopar_data", int'(by), 8'hA5);
    repeat (2) @(negedge CLK);

    // back-to-back: 0x3C then 0xFF presented in STOP
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
    @(negedge CLK);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge CLK);
      if (bus.mux_sel == 2'b00 && bus.busy) found = 1;
    end
    chk("b2b_reached_stop", int'(found), 1);
    bus.P_DATA = 8'hFF;
    @(negedge CLK);
    bus.DATA_VALID = 1'b0;
    chk("b2b_no_gap_mux", int'(bus.mux_sel), 1);
    chk("b2b_no_gap_busy", int'(bus.busy), 1);
    measure(-1, bc, by, pb, sp);
    chk("b2b_second_data", int'(by), 8'hFF);
    chk("b2b_second_busy", bc, 10);
    repeat (2) @(negedge CLK);

    // request during DATA is ignored and does not disturb the frame
    send(8'hA5, 1'b1, 1'b0);
    measure(3, bc, by, pb, sp);
    chk("prot_data", int'(by), 8'hA5);
    chk("prot_par", int'(pb), 0);
    chk("prot_busy_cycles", bc, 11);
    repeat (3) @(negedge CLK);
    chk("prot_not_sent", int'(bus.busy), 0);
    bus.PAR_TYP = 1'b0;

    // reset during the 4th data bit
    send(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    chk("rst_mid_in_data", int'(bus.mux_sel), 2);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid_mux", int'(bus.mux_sel), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    @(negedge CLK);
    send(8'h5A, 1'b1, 1'b0);
    measure(-1, bc, by, pb, sp);
    chk("post_rst_data", int'(by), 8'h5A);
    chk("post_rst_par", int'(pb), 0);
    chk("post_rst_busy", bc, 11);

    // reset wins over a same-edge request
    bus.P_DATA = 8'hFF; bus.DATA_VALID = 1'b1; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; bus.DATA_VALID = 1'b0;
    chk("rst_prio_busy", int'(bus.busy), 0);
    chk("rst_prio_mux", int'(bus.mux_sel), 0);
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
